// File: rtl/nibble_serial_adder.sv
// Wide-word add/subtract built on a 4-bit nibble datapath, one nibble per clock,
// LSB nibble first, with valid/ready handshakes on operands and result.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carryout,
    output logic                   overflow
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    result_q;
    logic            carry_q;
    logic            carryout_q;
    logic            overflow_q;
    logic [IW-1:0]   idx_q;

    logic [IW+1:0]   bit_off;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [4:0]      nib_sum;
    logic            last;
    logic [W-1:0]    result_d;

    always_comb begin
        bit_off  = {idx_q, 2'b00};
        a_sh     = a_q >> bit_off;
        b_sh     = b_q >> bit_off;
        nib_sum  = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, carry_q};
        last     = (idx_q == IW'(NIBBLES - 1));
        // Merge the fresh nibble into its slot; other nibbles keep their value.
        result_d = (result_q & ~(W'(4'hF) << bit_off))
                 | (W'(nib_sum[3:0]) << bit_off);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
            idx_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    result_q <= result_d;
                    carry_q  <= nib_sum[4];
                    idx_q    <= idx_q + 1'b1;
                    if (last) begin
                        carryout_q <= nib_sum[4];
                        overflow_q <= (a_q[W-1] == b_q[W-1])
                                   && (nib_sum[3] != a_q[W-1]);
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carryout  = carryout_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: vector table plus handshake corner cases,
// with results checked through a queue-based scoreboard.
module tb_nibble_serial_adder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        carryout;
    logic        overflow;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] r;
        logic        c;
        logic        o;
    } vec_t;

    typedef struct {
        logic [15:0] r;
        logic        c;
        logic        o;
    } exp_t;

    vec_t  tbl[8];
    exp_t  exp_q[$];
    int    rise_q[$];
    int    rises[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    logic  ov_prev = 1'b0;
    exp_t  mon_e;
    int    mon_r;
    int    acc_cyc;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carryout  (carryout),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] x,
                                   input logic [15:0] y,
                                   input logic s);
        exp_t        e;
        logic [15:0] yy;
        logic [16:0] t;
        yy  = s ? ~y : y;
        t   = {1'b0, x} + {1'b0, yy} + {16'd0, s};
        e.r = t[15:0];
        e.c = t[16];
        e.o = (x[15] == yy[15]) && (t[15] != x[15]);
        return e;
    endfunction

    // Scoreboard: latency on each out_valid rise, payload on each transfer.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            rise_q.delete();
        end else begin
            if (out_valid && !ov_prev) begin
                rises.push_back(cyc);
                if (rise_q.size() > 0) begin
                    mon_r = rise_q.pop_front();
                    chk("latency", cyc, mon_r);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output got %0h expected none",
                             result);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("result", result, mon_e.r);
                    chk("carryout", carryout, mon_e.c);
                    chk("overflow", overflow, mon_e.o);
                end
            end
        end
        ov_prev = out_valid;
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [15:0] xa, input logic [15:0] xb,
                        input logic xs, input exp_t e, input bit keep);
        bit ok;
        ok       = 1'b0;
        a        = xa;
        b        = xb;
        sub      = xs;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready && !reset) begin
                exp_q.push_back(e);
                rise_q.push_back(cyc + 5);
                acc_cyc = cyc;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got 0 expected 1");
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        int   pulses;
        bit   seen;
        int   d;

        tbl[0] = '{16'h0003, 16'h0002, 1'b0, 16'h0005, 1'b0, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        tbl[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_carryout", carryout, 0);
        chk("rst_overflow", overflow, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            e.r = tbl[i].r;
            e.c = tbl[i].c;
            e.o = tbl[i].o;
            send(tbl[i].a, tbl[i].b, tbl[i].sub, e, 1'b0);
            drain();
        end

        // Backpressure: result held while inputs churn, nothing accepted.
        out_ready = 1'b0;
        e = '{16'h3333, 1'b0, 1'b0};
        send(16'h1111, 16'h2222, 1'b0, e, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("bp_done_seen", seen, 1);
        d = cyc;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            a        = 16'($urandom);
            b        = 16'($urandom);
            sub      = 1'($urandom);
            in_valid = ~in_valid;
            @(negedge clk);
            d = cyc;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_result", result, 16'h3333);
            chk("bp_carryout", carryout, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        e = '{16'h0123, 1'b0, 1'b0};
        send(16'h0100, 16'h0023, 1'b0, e, 1'b0);
        chk("bp_accept_cycle", acc_cyc, d + 2);
        drain();

        // Reset lands on the second RUN cycle.
        e = '{16'h2345, 1'b0, 1'b0};
        send(16'h1234, 16'h1111, 1'b0, e, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", result, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("abort_no_pulse", pulses, 0);
        @(posedge clk);
        #1;
        e = '{16'h0002, 1'b0, 1'b0};
        send(16'h0001, 16'h0001, 1'b0, e, 1'b0);
        drain();

        // Back-to-back with in_valid and out_ready held high.
        rises.delete();
        for (int i = 0; i < 3; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rs;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            send(ra, rb, rs, model(ra, rb, rs), i < 2);
        end
        drain();
        chk("b2b_count", rises.size(), 3);
        if (rises.size() == 3) begin
            chk("b2b_gap0", rises[1] - rises[0], 6);
            chk("b2b_gap1", rises[2] - rises[1], 6);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide-word adder/subtractor that processes a `4*NIBBLES`-bit operand pair one 4-bit nibble per clock, least-significant nibble first, with the carry held in a register between cycles. It sits directly in front of the team's 4-bit full-adder datapath and extends it to wider words. It adds the carry-in that the 4-bit adder lacks, sequences nibbles, and produces a registered wide sum with carryout and signed overflow. It uses valid/ready handshakes on both input and output.

## Interface
- `NIBBLES`, default 4: number of 4-bit nibbles per operand. W = 4*NIBBLES. Legal range 1..16.
- `clk` input, 1: single clock; all state updates on rising edge.
- `reset` input, 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `in_valid` input, 1: operand pair and `sub` presented.
- `in_ready` output, 1: block can accept an operation (high only in IDLE).
- `a` input, W: operand A, two's complement.
- `b` input, W: operand B, two's complement.
- `sub` input, 1: 0 = A+B, 1 = A-B.
- `out_valid` output, 1: result, carryout and overflow valid.
- `out_ready` input, 1: consumer takes result.
- `result` output, W: sum/difference modulo 2^W.
- `carryout` output, 1: carry out of MSB (for sub: 1 = no borrow).
- `overflow` output, 1: signed two's-complement overflow.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch `a`, latch `b` (inverted if `sub`=1) and `sub`. Set carry register = `sub`, nibble index = 0. Go to RUN.
- RUN, each cycle:
  - Nibble k = index. Compute 5-bit `a[k]+b'[k]+carry`.
  - Write low 4 bits into `result` nibble k. Carry register = bit 4. Index increments.
  - On last nibble (index = NIBBLES-1): `carryout` = bit 4. `overflow` = (a MSB == b' MSB) && (sum MSB != a MSB). Go to DONE.
- DONE:
  - `out_valid`=1. `result`, `carryout` and `overflow` held stable.
  - On `out_ready`=1: go to IDLE.
  - `in_valid` ignored.
- Input handshake: transfer when `in_valid && in_ready`. Inputs are sampled only on that edge; later changes to `a`, `b` and `sub` have no effect.
- Output handshake: transfer when `out_valid && out_ready`. `out_valid` stays high until the transfer.
- Width rules:
  - `result` is truncated modulo 2^W.
  - Index counter width is ceil(log2(NIBBLES))+1.
  - NIBBLES=1 degenerates to one RUN cycle.
- `result` nibbles not yet written in RUN hold stale values. They are not observable because `out_valid`=0.

## Timing
- Reset values (after reset edge): state IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `carryout`=0, `overflow`=0, carry register=0, index=0.
- Latency: operation accepted at edge T, `out_valid` high after edge T+NIBBLES.
- Throughput: one operation per NIBBLES+2 cycles with `out_ready` held high.
- With `out_ready` high on the first DONE cycle, `in_ready` returns high after the next edge. No overlap of operations.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Reset mid-RUN or in DONE aborts the operation at that edge:
  - outputs take their reset values;
  - no `out_valid` pulse occurs for the aborted operation.
- Reset asserted together with `in_valid` takes precedence: the operation is not accepted.

## Test plan
All scenarios use NIBBLES=4.
- 0x0003 + 0x0002, `sub`=0 -> `result`=0x0005, `carryout`=0, `overflow`=0. `out_valid` rises exactly 4 cycles after acceptance.
- 0x7FFF + 0x0001 -> 0x8000, `carryout`=0, `overflow`=1. 0xFFFF + 0x0001 -> 0x0000, `carryout`=1, `overflow`=0. Both carries ripple through all nibbles.
- Subtract: 0x0005 - 0x0007 -> 0xFFFE, `carryout`=0, `overflow`=0. 0x8000 - 0x0001 -> 0x7FFF, `carryout`=1, `overflow`=1.
- Backpressure: hold `out_ready`=0 for 3 DONE cycles while toggling `a`, `b` and `in_valid`. Required: outputs stable, `in_ready`=0, nothing accepted. Then `out_ready`=1 -> IDLE next cycle and the new operation is accepted.
- Reset on the 2nd RUN cycle of 0x1234 + 0x1111 -> IDLE after that edge, `result`=0, no `out_valid` pulse. A following 0x0001 + 0x0001 -> 0x0002.
- Back-to-back: `in_valid` and `out_ready` held high for 3 operations -> results spaced exactly 6 cycles apart, each correct.
